// File: rtl/accum_pkg.sv
// accum_pkg: shared types, default sizes and the per-column add helper
// for the accum_bank double-buffered accumulator memory.
//
// Contents:
//   acc_state_e  - control FSM states (IDLE, CLEAR, SWAP)
//   acc_mode_e   - write mode (overwrite / accumulate)
//   ACC_*        - default parameter values for accum_bank
//   acc_add()    - signed add of one column, wrapping or saturating
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SWAP  = 2'd2
  } acc_state_e;

  typedef enum logic {
    ACC_OVERWRITE  = 1'b0,
    ACC_ACCUMULATE = 1'b1
  } acc_mode_e;

  localparam int ACC_NUM_COLS = 2;
  localparam int ACC_COL_W    = 32;
  localparam int ACC_DEPTH    = 256;

  // Result of one column add. val carries the full 64-bit sum; the caller
  // keeps the low COL_W bits, which gives modulo-2^COL_W wrap when no
  // clamping happened.
  typedef struct packed {
    logic [63:0] val;
    logic        sat;
  } add_res_t;

  // Operands arrive sign-extended to 64 bits, so for column widths up to
  // 63 bits the 64-bit sum cannot overflow and the range test is exact.
  function automatic add_res_t acc_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        w,
                                       input logic               sat_en);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    add_res_t           r;
    sum   = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.val = sum;
    r.sat = 1'b0;
    if (sat_en && (sum > hi)) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (sat_en && (sum < lo)) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_sdp_ram.sv
// accum_sdp_ram: one simple-dual-port block RAM, DEPTH x DATA_W.
// One synchronous write port, one synchronous read port. The array has no
// reset so it maps onto block RAM; rdata holds its value when re is low.
//
// Ports:
//   clk           clock
//   we/waddr/wdata  write port
//   re/raddr        read request and address
//   rdata           registered read data, valid the cycle after re
module accum_sdp_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // A read of the address being written in the same cycle returns the old
  // word; the owner of the write port forwards around that case.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/accum_bank.sv
// accum_bank: ping-pong accumulator memory between the systolic array and
// the VPU. The array writes partial sums into the fill buffer (overwrite or
// per-column accumulate); the VPU reads finished results from the drain
// buffer. A small FSM sequences buffer swap and an address-walking clear.
//
// Optional feature macro: ACC_SAT_EN
//   defined   - accumulate saturates per column; sat_flag port exists
//   undefined - accumulate wraps modulo 2^COL_W; no sat_flag port
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_en/wr_mode/wr_addr/wr_data, wr_ready   fill-side write port
//   rd_en/rd_addr, rd_data/rd_valid           drain-side read port
//   clear_req/clear_done       zero the whole fill buffer
//   swap_req/swap_done         exchange fill and drain buffers
//   fill_sel                   current fill buffer index (drain = ~fill_sel)
//   sat_flag                   sticky saturation flag (ACC_SAT_EN only)
//
// Handshake: a write transfers on a rising edge where wr_en && wr_ready;
// wr_ready does not depend on wr_en, and wr_en with wr_ready low has no
// effect. Reads and the clear/swap pulses are always taken.
module accum_bank
  import accum_pkg::*;
#(
  parameter int NUM_COLS = ACC_NUM_COLS,
  parameter int COL_W    = ACC_COL_W,
  parameter int DEPTH    = ACC_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic                      wr_mode,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [NUM_COLS*COL_W-1:0] wr_data,
  output logic                      wr_ready,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [NUM_COLS*COL_W-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      clear_req,
  output logic                      clear_done,
  input  logic                      swap_req,
  output logic                      swap_done,
  output logic                      fill_sel
`ifdef ACC_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam int DATA_W = NUM_COLS * COL_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Control FSM state and pending requests
  acc_state_e        state_q, state_d;
  logic              swap_pend_q, swap_pend_d;
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_fin_q, clr_fin_d;
  logic              fill_sel_q, fill_sel_d;
  logic              clear_done_q, clear_done_d;
  logic              swap_done_q, swap_done_d;

  // Write pipeline stage S1
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  acc_mode_e         s1_mode_q, s1_mode_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_fwd_q, s1_fwd_d;
  logic [DATA_W-1:0] s1_fwd_word_q, s1_fwd_word_d;
  logic [DATA_W-1:0] s1_new;
  logic              s1_sat;

  // Read side
  logic              rd_valid_q, rd_valid_d;
  logic              rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
  logic [DATA_W-1:0] rd_data_mux;

  // Sticky saturation flag (stays 0 when saturation is disabled)
  logic              sat_q, sat_d;

  // RAM hookup
  logic              wr_acc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata [2];
  logic [DATA_W-1:0] fill_rdata;
  logic [DATA_W-1:0] old_word;

  assign wr_ready = (state_q == IDLE) && !swap_pend_q && !clr_pend_q;
  assign wr_acc   = wr_en && wr_ready;

  // Each buffer's read port serves the write pipeline while it is the fill
  // buffer and the VPU while it is the drain buffer, so the two sides never
  // contend for a port.
  for (genvar b = 0; b < 2; b++) begin : g_buf
    logic is_fill;
    assign is_fill = (fill_sel_q == 1'(b));
    accum_sdp_ram #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_ram (
      .clk  (clk),
      .we   (is_fill && ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .re   (is_fill ? wr_acc : rd_en),
      .raddr(is_fill ? wr_addr : rd_addr),
      .rdata(ram_rdata[b])
    );
  end

  // S1 new-word computation. When the previous write hit the same address
  // its result is not yet readable from RAM, so the forwarded copy is used.
  always_comb begin : s1_calc
    add_res_t                res;
    logic signed [COL_W-1:0] old_c;
    logic signed [COL_W-1:0] dat_c;
    fill_rdata = fill_sel_q ? ram_rdata[1] : ram_rdata[0];
    old_word   = s1_fwd_q ? s1_fwd_word_q : fill_rdata;
    s1_new     = s1_data_q;
    s1_sat     = 1'b0;
    res        = '0;
    old_c      = '0;
    dat_c      = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      old_c = old_word[c*COL_W +: COL_W];
      dat_c = s1_data_q[c*COL_W +: COL_W];
      res   = acc_add(64'(old_c), 64'(dat_c), COL_W, SAT_EN);
      if (s1_mode_q == ACC_ACCUMULATE) begin
        s1_new[c*COL_W +: COL_W] = res.val[COL_W-1:0];
        s1_sat                   = s1_sat | res.sat;
      end
    end
  end

  // RAM write port: the pipeline has priority; the clear walk only runs
  // once S1 has drained.
  always_comb begin
    ram_we    = s1_valid_q;
    ram_waddr = s1_addr_q;
    ram_wdata = s1_new;
    if ((state_q == CLEAR) && !s1_valid_q && !clr_fin_q) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end
  end

  // Pipeline and read-side next state
  always_comb begin
    s1_valid_d    = wr_acc;
    s1_addr_d     = wr_acc ? wr_addr : s1_addr_q;
    s1_mode_d     = wr_acc ? acc_mode_e'(wr_mode) : s1_mode_q;
    s1_data_d     = wr_acc ? wr_data : s1_data_q;
    s1_fwd_d      = wr_acc && s1_valid_q && (s1_addr_q == wr_addr);
    s1_fwd_word_d = s1_new;

    // rd_sel remembers which RAM the read went to, so a swap in the cycle
    // after a read does not redirect its result.
    rd_valid_d  = rd_en;
    rd_sel_d    = rd_en ? ~fill_sel_q : rd_sel_q;
    rd_data_mux = rd_valid_q ? ram_rdata[rd_sel_q] : rd_hold_q;
    rd_hold_d   = rd_data_mux;
  end

  // Control FSM next state
  always_comb begin
    state_d      = state_q;
    swap_pend_d  = swap_pend_q;
    clr_pend_d   = clr_pend_q;
    clr_addr_d   = clr_addr_q;
    clr_fin_d    = clr_fin_q;
    fill_sel_d   = fill_sel_q;
    clear_done_d = 1'b0;
    swap_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d     = CLEAR;
          swap_pend_d = swap_req;
          clr_addr_d  = '0;
          clr_fin_d   = 1'b0;
        end else if (swap_req) begin
          state_d = SWAP;
        end
      end
      CLEAR: begin
        if (swap_req) swap_pend_d = 1'b1;
        if (clr_fin_q) begin
          // clear_done is showing this cycle; leave now
          clr_fin_d = 1'b0;
          if (swap_pend_q || swap_req) begin
            state_d     = SWAP;
            swap_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (!s1_valid_q) begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_ADDR) begin
            clr_fin_d    = 1'b1;
            clear_done_d = 1'b1;
          end
        end
      end
      SWAP: begin
        if (clear_req) clr_pend_d = 1'b1;
        if (!s1_valid_q) begin
          fill_sel_d  = ~fill_sel_q;
          swap_done_d = 1'b1;
          if (clr_pend_q || clear_req) begin
            state_d    = CLEAR;
            clr_pend_d = 1'b0;
            clr_addr_d = '0;
            clr_fin_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    sat_d = sat_q | (s1_valid_q && (s1_mode_q == ACC_ACCUMULATE) && s1_sat);
    if (clear_done_d) sat_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      swap_pend_q   <= 1'b0;
      clr_pend_q    <= 1'b0;
      clr_addr_q    <= '0;
      clr_fin_q     <= 1'b0;
      fill_sel_q    <= 1'b0;
      clear_done_q  <= 1'b0;
      swap_done_q   <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_mode_q     <= ACC_OVERWRITE;
      s1_data_q     <= '0;
      s1_fwd_q      <= 1'b0;
      s1_fwd_word_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_hold_q     <= '0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      swap_pend_q   <= swap_pend_d;
      clr_pend_q    <= clr_pend_d;
      clr_addr_q    <= clr_addr_d;
      clr_fin_q     <= clr_fin_d;
      fill_sel_q    <= fill_sel_d;
      clear_done_q  <= clear_done_d;
      swap_done_q   <= swap_done_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s1_mode_q     <= s1_mode_d;
      s1_data_q     <= s1_data_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_word_q <= s1_fwd_word_d;
      rd_valid_q    <= rd_valid_d;
      rd_sel_q      <= rd_sel_d;
      rd_hold_q     <= rd_hold_d;
      sat_q         <= sat_d;
    end
  end

  assign rd_data    = rd_data_mux;
  assign rd_valid   = rd_valid_q;
  assign clear_done = clear_done_q;
  assign swap_done  = swap_done_q;
  assign fill_sel   = fill_sel_q;
`ifdef ACC_SAT_EN
  assign sat_flag   = sat_q;
`endif

endmodule

// File: doc/accum_bank.md
# accum_bank

Parametrised, double-buffered (ping-pong) accumulator memory between the systolic array and the VPU. The array writes partial sums into the fill buffer, either overwriting or read-modify-write accumulating per column. The VPU reads finished results from the drain buffer. A small FSM sequences buffer swap and a BRAM-friendly address-walking clear, with write-side flow control.

## Interface
- NUM_COLS, 2: independent accumulator columns per word
- COL_W, 32: bits per column, signed two's complement
- DEPTH, 256: entries per buffer, power of two
- ADDR_W, $clog2(DEPTH): address width
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request; accepted when wr_en && wr_ready
- wr_mode  in  1  0 = overwrite, 1 = accumulate into stored value
- wr_addr  in  ADDR_W  fill-buffer address
- wr_data  in  NUM_COLS*COL_W  column 0 in LSBs
- wr_ready  out  1  write port can accept
- rd_en  in  1  read request to the drain buffer, always accepted
- rd_addr  in  ADDR_W  drain-buffer address
- rd_data  out  NUM_COLS*COL_W  read result; holds its value when no read is issued
- rd_valid  out  1  rd_data updated this cycle
- clear_req  in  1  pulse: zero the entire fill buffer
- clear_done  out  1  one-cycle pulse when the clear completes
- swap_req  in  1  pulse: exchange fill and drain buffers
- swap_done  out  1  one-cycle pulse when the swap takes effect
- fill_sel  out  1  index of the current fill buffer; drain = ~fill_sel

## Operation
- Storage: two simple-dual-port RAMs, DEPTH x NUM_COLS*COL_W each. Contents are not reset and are undefined until cleared or written.
- Write pipeline, two stages:
  - S0: an accepted write issues a synchronous read of wr_addr on the fill buffer.
  - S1: computes the new word and writes it.
  - Overwrite mode: new word = wr_data.
  - Accumulate mode: per column, new = old + wr_data[col]. There is no carry between columns.
- Hazard: if S1 holds the same address as the incoming write, "old" is forwarded from S1's new value, not from RAM. Back-to-back accumulates to one address must sum correctly.
- Read: on rd_en, drain[rd_addr] is registered into rd_data and rd_valid is asserted for that cycle.
- FSM states IDLE, CLEAR, SWAP:
  - IDLE -> CLEAR on clear_req.
  - IDLE -> SWAP on swap_req without clear_req.
  - clear_req and swap_req in the same cycle: CLEAR first, then SWAP (the swap is latched pending).
  - swap_req arriving during CLEAR is latched and serviced after CLEAR.
  - clear_req during SWAP is latched and serviced after SWAP, on the new fill buffer.
- CLEAR: wr_ready = 0. Waits until S1 is empty, then writes zero to addresses 0..DEPTH-1, one per cycle. clear_done pulses in the cycle after the last address is written, then the FSM returns to IDLE or pending SWAP.
- SWAP: wr_ready = 0. Waits until S1 is empty, toggles fill_sel, pulses swap_done in the same cycle, then returns to IDLE or pending CLEAR.
- wr_ready = 1 only in IDLE with no pending request. wr_en while wr_ready = 0 is ignored with no side effect.
- Reset mid-operation: the FSM returns to IDLE, pending flags and pipeline are dropped, and RAM contents are left as they are.
- Reset values: wr_ready = 1, rd_data = 0, rd_valid = 0, clear_done = 0, swap_done = 0, fill_sel = 0.

## Timing
- Write latency: a write accepted at edge N lands in RAM at edge N+1 and is visible to a drain read only after a swap.
- Sustained throughput: 1 write per cycle in either mode.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data.
- Reads during the swap cycle use the pre-toggle drain buffer. The first read on the new drain buffer is issued in the cycle after swap_done.
- Swap from an idle pipeline: swap_req at edge N gives swap_done at cycle N+1 (2 cycles with S1 busy).
- Clear: DEPTH + 1 cycles from entering CLEAR (with S1 empty) to clear_done.
- Read and write ports never touch the same RAM, so there are no read/write collisions.

## Configuration
- ACC_SAT_EN defined: accumulate is signed saturating per column, clamping to [-2^(COL_W-1), 2^(COL_W-1)-1]. Output sat_flag (1 bit) is a sticky OR of saturation events, cleared by clear_done or reset.
- ACC_SAT_EN undefined: accumulate wraps modulo 2^COL_W, and no sat_flag port exists.

## Structure
- accum_pkg holds:
  - enum acc_state_e {IDLE, CLEAR, SWAP}
  - enum acc_mode_e {ACC_OVERWRITE, ACC_ACCUMULATE}
  - default parameter constants
  - sat/wrap add function
- Sub-module accum_sdp_ram: one simple-dual-port RAM with ram_style = "block", synchronous read, no reset on the array. It is instantiated twice.

## Test plan
- Reset, clear, write overwrite 0x0000_0005/0x0000_0003 to addr 7, swap, read 7 -> rd_data = {3,5} one cycle later with rd_valid; fill_sel = 1.
- Three back-to-back accumulate writes of {1,2} to addr 9 after a clear, swap, read 9 -> {3,6}, confirming the forwarding path.
- clear_req and swap_req in the same cycle -> DEPTH+1 cycles of wr_ready = 0 then clear_done, then swap_done; the new drain buffer reads all zeros.
- wr_en during CLEAR with data 0xFF -> ignored; after clear_done all addresses read 0 after swap.
- Accumulate 0x7FFF_FFFF + 1 in a column -> with ACC_SAT_EN: 0x7FFF_FFFF and sat_flag = 1; without: 0x8000_0000.
- Assert rst_n low mid-CLEAR (address 100) -> outputs take reset values immediately; the next clear_req completes normally.
